// File: rtl/h80bus_arbiter.sv
// h80bus_arbiter: two-master round-robin arbiter and strobe sequencer for the h80 bus
module h80bus_arbiter #(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                m_req,
  input  logic [1:0]                m_io,
  input  logic [BUS_ADDR_WIDTH-1:0] m0_addr,
  input  logic [BUS_ADDR_WIDTH-1:0] m1_addr,
  input  logic [BUS_CMD_WIDTH-1:0]  m0_cmd,
  input  logic [BUS_CMD_WIDTH-1:0]  m1_cmd,
  input  logic [BUS_DATA_WIDTH-1:0] m0_wdata,
  input  logic [BUS_DATA_WIDTH-1:0] m1_wdata,
  output logic [1:0]                m_grant,
  output logic [1:0]                m_done,
  output logic [1:0]                m_err,
  output logic [BUS_DATA_WIDTH-1:0] m_rdata,
  output logic                      mreq_n,
  output logic                      iorq_n,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic [BUS_DATA_WIDTH-1:0] bus_rdata,
  input  logic                      bus_wait_n
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  state_t state, state_nx;
  logic last_grant, win, tmo;
  logic [CW-1:0] cnt;
  // on a tie the master that did not win last time takes the bus
  assign win = &m_req ? ~last_grant : m_req[1];
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = |m_req ? ACCESS : IDLE;
      ACCESS:  state_nx = (bus_wait_n || tmo) ? RELEASE : ACCESS;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mreq_n     <= 1'b1;
      iorq_n     <= 1'b1;
      m_grant    <= '0;
      m_done     <= '0;
      m_err      <= '0;
      m_rdata    <= '0;
      bus_addr   <= '0;
      bus_cmd    <= '0;
      bus_wdata  <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      m_done <= '0;
      m_err  <= '0;
      case (state)
        IDLE: if (|m_req) begin
          bus_addr   <= win ? m1_addr : m0_addr;
          bus_cmd    <= win ? m1_cmd : m0_cmd;
          bus_wdata  <= win ? m1_wdata : m0_wdata;
          m_grant    <= win ? 2'b10 : 2'b01;
          mreq_n     <= m_io[win];
          iorq_n     <= ~m_io[win];
          last_grant <= win;
          cnt        <= '0;
        end
        ACCESS: if (bus_wait_n) begin
          m_rdata <= bus_rdata;
          m_done  <= m_grant;
          mreq_n  <= 1'b1;
          iorq_n  <= 1'b1;
        end else if (tmo) begin
          m_err  <= m_grant;
          mreq_n <= 1'b1;
          iorq_n <= 1'b1;
        end else cnt <= cnt + CW'(1);
        default: m_grant <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_h80bus_arbiter.sv
// tb_h80bus_arbiter: directed scenario tests for h80bus_arbiter (TIMEOUT_CYCLES=4)
module tb_h80bus_arbiter;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [1:0]  m_req = 0, m_io = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [2:0]  m0_cmd = 0, m1_cmd = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [1:0]  m_grant, m_done, m_err;
  logic [31:0] m_rdata, bus_wdata, bus_rdata = 0;
  logic        mreq_n, iorq_n, bus_wait_n = 1;
  logic [15:0] bus_addr;
  logic [2:0]  bus_cmd;
  int tests = 0, fails = 0;

  h80bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .m_req(m_req), .m_io(m_io),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_cmd(m0_cmd), .m1_cmd(m1_cmd),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m_grant(m_grant), .m_done(m_done),
    .m_err(m_err), .m_rdata(m_rdata), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_wait_n(bus_wait_n)
  );

  always #5 clk = ~clk;

  task test_reset;
    @(negedge clk);
    tests++; if ({mreq_n, iorq_n} !== 2'b11) begin fails++; $display("FAIL reset_strobes got %b want 11", {mreq_n, iorq_n}); end
    tests++; if ({m_grant, m_done, m_err} !== 6'b0) begin fails++; $display("FAIL reset_flags got %b want 0", {m_grant, m_done, m_err}); end
    tests++; if ({bus_addr, bus_cmd, bus_wdata, m_rdata} !== '0) begin fails++; $display("FAIL reset_regs got %h want 0", {bus_addr, bus_cmd, bus_wdata, m_rdata}); end
    reset_n = 1;
  endtask

  task test_single_read;
    @(negedge clk);
    m_req = 2'b01; m_io = 2'b00; m0_addr = 16'h1234; m0_cmd = 3'd2; m0_wdata = 32'h0BADF00D;
    bus_wait_n = 1; bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    tests++; if ({mreq_n, iorq_n} !== 2'b01) begin fails++; $display("FAIL rd_strobe got %b want 01", {mreq_n, iorq_n}); end
    tests++; if (bus_addr !== 16'h1234) begin fails++; $display("FAIL rd_addr got %h want 1234", bus_addr); end
    tests++; if (bus_cmd !== 3'd2 || bus_wdata !== 32'h0BADF00D) begin fails++; $display("FAIL rd_cmd_wdata got %h/%h want 2/0badf00d", bus_cmd, bus_wdata); end
    tests++; if (m_grant !== 2'b01 || m_done !== 2'b00) begin fails++; $display("FAIL rd_grant got %b/%b want 01/00", m_grant, m_done); end
    @(negedge clk);
    tests++; if ({mreq_n, iorq_n} !== 2'b11) begin fails++; $display("FAIL rd_release got %b want 11", {mreq_n, iorq_n}); end
    tests++; if (m_done !== 2'b01 || m_grant !== 2'b01) begin fails++; $display("FAIL rd_done got %b/%b want 01/01", m_done, m_grant); end
    tests++; if (m_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data got %h want deadbeef", m_rdata); end
    m_req = 2'b00;
    @(negedge clk);
    tests++; if (m_done !== 2'b00 || m_grant !== 2'b00) begin fails++; $display("FAIL rd_idle got %b/%b want 00/00", m_done, m_grant); end
  endtask

  task test_wait_states;
    int low, dn, bad;
    low = 0; dn = 0; bad = 0;
    @(negedge clk);
    m_req = 2'b10; m_io = 2'b10; m1_addr = 16'hBEEF; bus_wait_n = 0; bus_rdata = 32'h00001111;
    for (int i = 0; i < 20 && dn == 0; i++) begin
      @(negedge clk);
      if (iorq_n === 1'b0) begin low++; if (m_grant !== 2'b10) bad++; end
      if (mreq_n !== 1'b1 || m_err !== 2'b00) bad++;
      if (m_done === 2'b10) dn++; else if (m_done !== 2'b00) bad++;
      bus_wait_n = low >= 4;
    end
    tests++; if (low !== 4) begin fails++; $display("FAIL wait_len got %0d want 4", low); end
    tests++; if (dn !== 1) begin fails++; $display("FAIL wait_done got %0d want 1", dn); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL wait_owner got %0d bad cycles want 0", bad); end
    tests++; if (m_rdata !== 32'h00001111 || m_grant !== 2'b10) begin fails++; $display("FAIL wait_data got %h/%b want 00001111/10", m_rdata, m_grant); end
    m_req = 2'b00;
    @(negedge clk);
    tests++; if (m_done !== 2'b00 || m_grant !== 2'b00) begin fails++; $display("FAIL wait_pulse got %b/%b want 00/00", m_done, m_grant); end
  endtask

  task test_round_robin;
    logic [1:0] g [4];
    int n, dn, bad;
    logic prev_low;
    n = 0; dn = 0; bad = 0; prev_low = 0;
    @(negedge clk);
    m_req = 2'b11; m_io = 2'b00; bus_wait_n = 1; bus_rdata = 32'hCAFE0001;
    for (int i = 0; i < 40 && dn < 4; i++) begin
      @(negedge clk);
      if (mreq_n === 1'b0) begin
        if (prev_low) bad++;
        else if (n < 4) begin g[n] = m_grant; n++; end
      end
      prev_low = mreq_n === 1'b0;
      if (m_done !== 2'b00) dn++;
      if (iorq_n !== 1'b1) bad++;
    end
    m_req = 2'b00;
    tests++; if (n !== 4) begin fails++; $display("FAIL rr_count got %0d want 4", n); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rr_gap got %0d bad cycles want 0", bad); end
    for (int i = 0; i < n; i++) begin
      tests++; if (g[i] !== ((i % 2) ? 2'b10 : 2'b01)) begin fails++; $display("FAIL rr_grant%0d got %b want %b", i, g[i], (i % 2) ? 2'b10 : 2'b01); end
    end
    tests++; if (m_rdata !== 32'hCAFE0001) begin fails++; $display("FAIL rr_data got %h want cafe0001", m_rdata); end
    @(negedge clk);
  endtask

  task test_timeout;
    int low, er, dn;
    low = 0; er = 0; dn = 0;
    @(negedge clk);
    m_req = 2'b01; m_io = 2'b00; bus_wait_n = 0; bus_rdata = 32'h12345678;
    for (int i = 0; i < 20 && er == 0; i++) begin
      @(negedge clk);
      if (mreq_n === 1'b0) low++;
      if (m_err === 2'b01) er++; else if (m_err !== 2'b00) er += 10;
      if (m_done !== 2'b00) dn++;
    end
    tests++; if (low !== 4) begin fails++; $display("FAIL to_len got %0d want 4", low); end
    tests++; if (er !== 1) begin fails++; $display("FAIL to_err got %0d want 1", er); end
    tests++; if (dn !== 0) begin fails++; $display("FAIL to_done got %0d want 0", dn); end
    tests++; if (m_rdata !== 32'hCAFE0001) begin fails++; $display("FAIL to_data got %h want cafe0001", m_rdata); end
    m_req = 2'b00;
    @(negedge clk);
    tests++; if (m_err !== 2'b00 || m_grant !== 2'b00) begin fails++; $display("FAIL to_pulse got %b/%b want 00/00", m_err, m_grant); end
    bus_wait_n = 1;
  endtask

  task test_input_stability;
    int low, bad, dn;
    low = 0; bad = 0; dn = 0;
    @(negedge clk);
    m_req = 2'b01; m_io = 2'b00; m0_addr = 16'hAAAA; m0_cmd = 3'd5; bus_wait_n = 0;
    for (int i = 0; i < 20 && dn == 0; i++) begin
      @(negedge clk);
      if (mreq_n === 1'b0) begin
        low++;
        if (bus_addr !== 16'hAAAA || bus_cmd !== 3'd5) bad++;
        m0_addr = 16'h5555 + 16'(i); m0_cmd = 3'(i);
      end
      if (m_done === 2'b01) dn++;
      bus_wait_n = low >= 3;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL stable_bus got %0d bad cycles want 0", bad); end
    tests++; if (low !== 3 || dn !== 1) begin fails++; $display("FAIL stable_len got %0d/%0d want 3/1", low, dn); end
    tests++; if (bus_addr !== 16'hAAAA) begin fails++; $display("FAIL stable_after got %h want aaaa", bus_addr); end
    m_req = 2'b00;
    @(negedge clk);
  endtask

  task test_reset_mid_access;
    @(negedge clk);
    m_req = 2'b10; m_io = 2'b10; bus_wait_n = 0;
    @(negedge clk);
    tests++; if (iorq_n !== 1'b0) begin fails++; $display("FAIL rst_pre got %b want 0", iorq_n); end
    #2 reset_n = 0;
    #1;
    tests++; if ({mreq_n, iorq_n} !== 2'b11) begin fails++; $display("FAIL rst_async got %b want 11", {mreq_n, iorq_n}); end
    tests++; if ({m_grant, m_done, m_err} !== 6'b0) begin fails++; $display("FAIL rst_flags got %b want 0", {m_grant, m_done, m_err}); end
    m_req = 2'b11; m_io = 2'b00; bus_wait_n = 1;
    @(negedge clk);
    tests++; if ({m_done, m_err} !== 4'b0) begin fails++; $display("FAIL rst_nodone got %b want 0", {m_done, m_err}); end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    tests++; if (m_grant !== 2'b01 || mreq_n !== 1'b0) begin fails++; $display("FAIL rst_first got %b/%b want 01/0", m_grant, mreq_n); end
    @(negedge clk);
    tests++; if (m_done !== 2'b01) begin fails++; $display("FAIL rst_done got %b want 01", m_done); end
    m_req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_wait_states;
    test_round_robin;
    test_timeout;
    test_input_stability;
    test_reset_mid_access;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/h80bus_arbiter.md
Name: h80bus_arbiter

Overview:
Two-master arbiter and bus sequencer for the h80 bus. It lets the CPU (master 0) and a second master, such as a debug or DMA engine (master 1), share one memory/IO slave side. It grants one master at a time by round-robin, drives mreq_n/iorq_n, address, command and write data, and honours bus_wait_n. It ends each access with a done pulse, or with an error pulse on timeout. Read and write data use separate unidirectional paths; there is no tristate.

Parameters:
BUS_ADDR_WIDTH, 16, address width
BUS_CMD_WIDTH, 3, command width (opaque; passed through)
BUS_DATA_WIDTH, 32, data width
TIMEOUT_CYCLES, 255, max ACCESS cycles with bus_wait_n low before abort; minimum 1; counter width $clog2(TIMEOUT_CYCLES+1)

Ports:
clk  in  1  clock; all state changes on posedge
reset_n  in  1  asynchronous, active-low reset
m_req  in  2  per-master request; held high until that master's m_done or m_err
m_io  in  2  per-master space select: 1=IO (iorq_n), 0=memory (mreq_n)
m0_addr, m1_addr  in  BUS_ADDR_WIDTH  per-master address
m0_cmd, m1_cmd  in  BUS_CMD_WIDTH  per-master command
m0_wdata, m1_wdata  in  BUS_DATA_WIDTH  per-master write data
m_grant  out  2  one-hot owner, high from the latch cycle through the done/err cycle
m_done  out  2  one-cycle pulse to the owner on successful completion
m_err  out  2  one-cycle pulse to the owner on timeout
m_rdata  out  BUS_DATA_WIDTH  bus_rdata captured at completion; holds until the next completion
mreq_n, iorq_n  out  1  slave-side strobes; at most one low at any time
bus_addr  out  BUS_ADDR_WIDTH  registered address
bus_cmd  out  BUS_CMD_WIDTH  registered command
bus_wdata  out  BUS_DATA_WIDTH  registered write data
bus_rdata  in  BUS_DATA_WIDTH  slave read data, valid when bus_wait_n=1 during a strobe
bus_wait_n  in  1  slave ready; 0 extends the access

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE; mreq_n=iorq_n=1; m_grant=m_done=m_err=0; bus_addr/bus_cmd/bus_wdata/m_rdata=0; last_grant=1 (master 0 wins the first tie); timeout counter=0. Reset mid-access drops the strobe at once and sends no done.
- States are IDLE, ACCESS and RELEASE.
- IDLE:
  - If m_req!=0, pick a winner. With a single requester, it wins. With both requesting, the master other than last_grant wins.
  - Register the winner's addr/cmd/wdata onto the bus outputs and set m_grant.
  - Next cycle the state is ACCESS, with mreq_n or iorq_n low per m_io[winner]. Set last_grant=winner and clear the counter.
- ACCESS:
  - The strobe and bus outputs stay stable and are unaffected by any master input change.
  - If bus_wait_n==1 on a rising edge: m_rdata<=bus_rdata and m_done[owner] pulses in the next cycle. The strobe deasserts in that same cycle; state=RELEASE.
  - Else, if the counter equals TIMEOUT_CYCLES-1: m_err[owner] pulses, the strobe deasserts, state=RELEASE, and m_rdata is unchanged.
  - Else the counter increments.
- RELEASE:
  - m_grant clears on exit.
  - Strobes are high for exactly one cycle, which guarantees a bus gap.
  - Next state is IDLE. Requests are re-evaluated in IDLE, so back-to-back accesses take 3 cycles minimum: IDLE, ACCESS, RELEASE.
- Latency: with requests sampled in IDLE at edge N, the strobe is low after N and bus_wait_n is first sampled at N+1. With zero wait, done is high after N+1, so done appears 2 cycles after the request is seen.
- A request dropped during ACCESS is ignored; the access completes and the done/err pulse is still issued. Masters must not drop requests.
- Simultaneous new requests while busy are held off until IDLE. A newly rising request in RELEASE is not seen until IDLE.
- Done/err and grant go only to the owner; the non-owner's outputs stay 0.

Test Plan:
- Single read: m_req=01, m_io=0, m0_addr=16'h1234, bus_wait_n=1, bus_rdata=32'hDEADBEEF -> mreq_n low exactly 1 cycle, bus_addr=16'h1234, m_done=01 pulse 2 cycles after request, m_rdata=32'hDEADBEEF, iorq_n stays 1.
- Wait states: m_req=10, m_io=1, slave holds bus_wait_n=0 for 3 cycles -> iorq_n low for 4 cycles, m_done=10 single pulse, m_grant=10 throughout.
- Round-robin: m_req=11 held continuously, zero wait -> grants alternate 01,10,01,10. Every access is followed by a 1-cycle strobe-high gap.
- Timeout: TIMEOUT_CYCLES=4, bus_wait_n tied 0 -> strobe low exactly 4 cycles, m_err pulse to owner, m_done stays 0, m_rdata unchanged.
- Reset mid-access: assert reset_n=0 with the strobe low and bus_wait_n=0 -> mreq_n/iorq_n go high without waiting for a clock edge, no done/err. After release, m_req=11 grants master 0 first.
- Input stability: change m0_addr and m0_cmd during ACCESS with wait states -> bus_addr and bus_cmd stay at the values latched in IDLE.
